// File: rtl/esp8266_tx_arbiter_if.sv
// Bus between the three byte-stream sources, the UART TX core and
// esp8266_tx_arbiter. The master side is the requesters plus the UART model;
// the slave side is the arbiter itself.
interface esp8266_tx_arbiter_if;
  logic [2:0]  Req;
  logic [2:0]  Valid;
  logic [2:0]  Last;
  logic [23:0] Data;
  logic [2:0]  Ready;
  logic [2:0]  Grant;
  logic        Tx_start;
  logic [7:0]  Tx_data;
  logic        Tx_busy;
  logic        Busy;
  logic        Abort;
  logic [15:0] Frame_cnt;

  modport master (
    output Req, Valid, Last, Data, Tx_busy,
    input  Ready, Grant, Tx_start, Tx_data, Busy, Abort, Frame_cnt
  );

  modport slave (
    input  Req, Valid, Last, Data, Tx_busy,
    output Ready, Grant, Tx_start, Tx_data, Busy, Abort, Frame_cnt
  );
endinterface

// File: rtl/esp8266_tx_arbiter.sv
// esp8266_tx_arbiter: frame-level round-robin arbiter sharing the single
// ESP8266 UART transmitter between the sensor encoder (bit 0), the AT-command
// sequencer (bit 1) and the heartbeat generator (bit 2). A granted source owns
// the UART until its last byte, so frames are never interleaved.
// Optional feature macro: ARB_TIMEOUT_EN -- aborts a frame whose owner leaves
// LOAD starved of Valid for TIMEOUT consecutive cycles.
module esp8266_tx_arbiter #(
  parameter int GAP = 1000
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 50000
`endif
) (
  input logic                  Clk,
  input logic                  Rst_n,
  esp8266_tx_arbiter_if.slave  bus
);

  localparam int               GAP_W = $clog2(GAP) + 1;
  localparam logic [GAP_W-1:0] GAP_V = GAP_W'(GAP);
`ifdef ARB_TIMEOUT_EN
  localparam int              TO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_V = TO_W'(TIMEOUT);
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GUARD, WAIT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0]    to_q, to_d;
  logic               abort_q, abort_d;
`endif

  logic [1:0] sel_w;
  logic [1:0] gidx;
  logic       gap_done;
  logic       valid_g;
  logic       last_g;
  logic [7:0] data_g;
  logic [2:0] ready_w;
  logic       accept;

  // Round-robin pick: first set request bit starting at ptr+1, wrapping mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign sel_w    = rr_pick(bus.Req, ptr_q);
  assign gap_done = (gap_q >= GAP_V);
  assign ready_w  = (state_q == LOAD) ? (grant_q & bus.Valid) : 3'b000;
  assign accept   = |ready_w;

  // Steer the granted requester's byte, valid and last flag; ungranted ones are masked out.
  always_comb begin
    valid_g = |(bus.Valid & grant_q);
    last_g  = |(bus.Last & grant_q);
    gidx    = 2'd0;
    data_g  = bus.Data[7:0];
    if (grant_q[1]) begin
      gidx   = 2'd1;
      data_g = bus.Data[15:8];
    end else if (grant_q[2]) begin
      gidx   = 2'd2;
      data_g = bus.Data[23:16];
    end
  end

  // Next-state and next-output logic for the frame/byte sequencer.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    gap_d       = gap_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    frame_cnt_d = frame_cnt_q;
`ifdef ARB_TIMEOUT_EN
    to_d        = '0;
    abort_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!gap_done) gap_d = gap_q + GAP_W'(1);
        if (gap_done && (bus.Req != 3'b000)) begin
          grant_d = 3'b001 << sel_w;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          tx_data_d  = data_g;
          last_d     = last_g;
          tx_start_d = 1'b1;
          state_d    = SEND;
        end
`ifdef ARB_TIMEOUT_EN
        else if (!valid_g && (to_q == TO_V)) begin
          abort_d = 1'b1;
          grant_d = 3'b000;
          ptr_d   = gidx;
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      SEND: begin
        state_d = GUARD;
      end
      // The UART raises busy one cycle after the start pulse, so skip one look.
      GUARD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!bus.Tx_busy) begin
          if (last_q) begin
            grant_d     = 3'b000;
            ptr_d       = gidx;
            frame_cnt_d = frame_cnt_q + 16'd1;
            gap_d       = '0;
            state_d     = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; ptr resets to 2 so requester 0 wins first,
  // and the gap counter resets expired so the first grant is immediate.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 3'b000;
      ptr_q       <= 2'd2;
      gap_q       <= GAP_V;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
`ifdef ARB_TIMEOUT_EN
      to_q        <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef ARB_TIMEOUT_EN
      to_q        <= to_d;
      abort_q     <= abort_d;
`endif
    end
  end

  assign bus.Ready     = ready_w;
  assign bus.Grant     = grant_q;
  assign bus.Tx_start  = tx_start_q;
  assign bus.Tx_data   = tx_data_q;
  assign bus.Busy      = busy_q;
  assign bus.Frame_cnt = frame_cnt_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.Abort     = abort_q;
`else
  assign bus.Abort     = 1'b0;
`endif

endmodule

// File: tb/tb_esp8266_tx_arbiter.sv
// Bench for esp8266_tx_arbiter: three byte-queue requesters, a UART busy model,
// and a scoreboard monitor that checks every Tx_start against expected bytes.
module tb_esp8266_tx_arbiter;
  localparam int TB_GAP = 3;
`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 20;
`endif

  logic Clk = 1'b0;
  logic Rst_n;

  esp8266_tx_arbiter_if bus();

  esp8266_tx_arbiter #(
    .GAP(TB_GAP)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT(TB_TIMEOUT)
`endif
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  logic [8:0]  src2[$];
  logic [10:0] exp_q[$];
  logic [2:0]  req_en = 3'b000;
  logic [2:0]  vld_en = 3'b000;
  int          busy_len = 0;
  int          busy_rem = 0;

  int          cyc = 0;
  int          n_starts = 0;
  int          prev_start = -1;
  int          last_spacing = 0;
  int          abort_cnt = 0;
  int          last_abort = 0;
  logic [7:0]  held = 8'h00;
  logic        hold_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sp(input int i, input logic last, input logic [7:0] d);
    case (i)
      0: src0.push_back({last, d});
      1: src1.push_back({last, d});
      default: src2.push_back({last, d});
    endcase
  endtask

  task automatic ex(input logic [2:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return src0.size();
      1: return src1.size();
      default: return src2.size();
    endcase
  endfunction

  function automatic logic [8:0] qfront(input int i);
    case (i)
      0: return src0[0];
      1: return src1[0];
      default: return src2[0];
    endcase
  endfunction

  task automatic qpop(input int i);
    case (i)
      0: void'(src0.pop_front());
      1: void'(src1.pop_front());
      default: void'(src2.pop_front());
    endcase
  endtask

  task automatic drive();
    logic [2:0]  rq, vl, ls;
    logic [23:0] dt;
    logic [8:0]  f;
    rq = 3'b000; vl = 3'b000; ls = 3'b000; dt = 24'h0;
    for (int i = 0; i < 3; i++) begin
      if (qsize(i) > 0) begin
        f = qfront(i);
        rq[i] = req_en[i];
        vl[i] = vld_en[i];
        ls[i] = f[8];
        dt[8*i +: 8] = f[7:0];
      end
    end
    bus.Req = rq; bus.Valid = vl; bus.Last = ls; bus.Data = dt;
  endtask

  // Requester queues and UART busy model, updated just after each rising edge.
  initial begin
    logic [2:0] acc;
    logic       st;
    bus.Req = 3'b000; bus.Valid = 3'b000; bus.Last = 3'b000; bus.Data = 24'h0;
    bus.Tx_busy = 1'b0;
    forever begin
      @(negedge Clk);
      acc = bus.Ready;
      st  = bus.Tx_start;
      @(posedge Clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (acc[i] && qsize(i) > 0) qpop(i);
      if (st) begin
        busy_rem    = busy_len;
        bus.Tx_busy = (busy_len > 0);
      end else if (busy_rem > 0) begin
        busy_rem--;
        if (busy_rem == 0) bus.Tx_busy = 1'b0;
      end
      drive();
    end
  end

  // Scoreboard monitor: pops one expected {grant, byte} per Tx_start.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Rst_n) hold_ok = 1'b0;
      if (bus.Abort) begin
        abort_cnt++;
        last_abort = cyc;
      end
      check("ready_granted_only", 32'((bus.Ready & ~bus.Grant) | (bus.Busy ? 3'b000 : bus.Ready)), 32'd0);
      if (bus.Tx_start) begin
        n_starts++;
        check("start_uart_idle", 32'(bus.Tx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_start: got byte 0x%0h grant %b, expected none", bus.Tx_data, bus.Grant);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(bus.Tx_data), 32'(e[7:0]));
          check("tx_grant", 32'(bus.Grant), 32'(e[10:8]));
        end
        if (prev_start >= 0) last_spacing = cyc - prev_start;
        prev_start = cyc;
        held    = bus.Tx_data;
        hold_ok = 1'b1;
      end else if (bus.Tx_busy && hold_ok) begin
        check("tx_data_hold", 32'(bus.Tx_data), 32'(held));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_frames(input logic [15:0] target, input int bound, input string name);
    int n = 0;
    while (bus.Frame_cnt !== target && n < bound) begin
      @(negedge Clk);
      n++;
    end
    check(name, 32'(bus.Frame_cnt), 32'(target));
  endtask

  task automatic wait_starts(input int target, input int bound, input string name);
    int n = 0;
    while (n_starts < target && n < bound) begin
      @(negedge Clk);
      n++;
    end
    check(name, 32'(n_starts >= target), 32'd1);
  endtask

  task automatic flush_src();
    src0.delete(); src1.delete(); src2.delete();
    req_en = 3'b000;
    vld_en = 3'b000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},     32'(bus.Grant),     32'd0);
    check({tag, "_tx_start"},  32'(bus.Tx_start),  32'd0);
    check({tag, "_tx_data"},   32'(bus.Tx_data),   32'd0);
    check({tag, "_busy"},      32'(bus.Busy),      32'd0);
    check({tag, "_abort"},     32'(bus.Abort),     32'd0);
    check({tag, "_frame_cnt"}, 32'(bus.Frame_cnt), 32'd0);
    check({tag, "_ready"},     32'(bus.Ready),     32'd0);
  endtask

  initial begin
    int base;
    int idle;
    logic [15:0] fc;

    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Rst_n = 1'b1;

    // Single requester: "m", "(", "\n" with 10 busy cycles per byte
    busy_len = 10;
    sp(0, 1'b0, 8'h6D); sp(0, 1'b0, 8'h28); sp(0, 1'b1, 8'h0A);
    ex(3'b001, 8'h6D); ex(3'b001, 8'h28); ex(3'b001, 8'h0A);
    req_en = 3'b001; vld_en = 3'b001;
    @(negedge Clk);
    check("t1_grant_before_sample", 32'(bus.Grant), 32'd0);
    @(negedge Clk);
    check("t1_grant_latency", 32'(bus.Grant), 32'b001);
    check("t1_ready_in_load", 32'(bus.Ready), 32'b001);
    wait_frames(16'd1, 200, "t1_frame_cnt");
    check("t1_byte_period", 32'(last_spacing), 32'd13);
    check("t1_exp_drained", 32'(exp_q.size()), 32'd0);

    // Round-robin from reset: three-way tie, requester 0 repeats once
    Rst_n = 1'b0;
    flush_src();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    busy_len = 2;
    sp(0, 1'b1, 8'hA0); sp(0, 1'b1, 8'hA0); sp(1, 1'b1, 8'hA1); sp(2, 1'b1, 8'hA2);
    ex(3'b001, 8'hA0); ex(3'b010, 8'hA1); ex(3'b100, 8'hA2); ex(3'b001, 8'hA0);
    req_en = 3'b111; vld_en = 3'b111;
    wait_frames(16'd4, 400, "t2_frame_cnt");
    check("t2_exp_drained", 32'(exp_q.size()), 32'd0);

    // No interleave: requester 1 raises Req mid-frame, requester 0 drops Req mid-frame
    busy_len = 0;
    sp(0, 1'b0, 8'hB0); sp(0, 1'b0, 8'hB1); sp(0, 1'b0, 8'hB2); sp(0, 1'b0, 8'hB3); sp(0, 1'b1, 8'hB4);
    ex(3'b001, 8'hB0); ex(3'b001, 8'hB1); ex(3'b001, 8'hB2); ex(3'b001, 8'hB3); ex(3'b001, 8'hB4);
    ex(3'b010, 8'hC1);
    req_en = 3'b001; vld_en = 3'b001;
    base = n_starts;
    wait_starts(base + 2, 100, "t3_mid_frame");
    sp(1, 1'b1, 8'hC1);
    req_en = 3'b010; vld_en = 3'b011;
    wait_frames(16'd5, 200, "t3_frame_cnt");
    check("t3_min_byte_period", 32'(last_spacing), 32'd4);
    idle = 0;
    while (bus.Grant == 3'b000 && idle < 50) begin
      idle++;
      @(negedge Clk);
    end
    // TB_GAP gap cycles, then the single arbitration cycle
    check("t3_gap_idle_cycles", 32'(idle), 32'(TB_GAP + 1));
    check("t3_next_grant", 32'(bus.Grant), 32'b010);
    wait_frames(16'd6, 100, "t3_frame_cnt_after");
    check("t3_exp_drained", 32'(exp_q.size()), 32'd0);

    // Busy pacing: 1000 busy cycles per byte
    busy_len = 1000;
    sp(2, 1'b0, 8'hD0); sp(2, 1'b1, 8'hD1);
    ex(3'b100, 8'hD0); ex(3'b100, 8'hD1);
    req_en = 3'b100; vld_en = 3'b100;
    wait_frames(16'd7, 2600, "t4_frame_cnt");
    check("t4_byte_period", 32'(last_spacing), 32'd1003);
    check("t4_exp_drained", 32'(exp_q.size()), 32'd0);

    // Starvation: owner stops Valid after byte 2
    busy_len = 2;
    sp(0, 1'b0, 8'hE0); sp(0, 1'b0, 8'hE1); sp(0, 1'b1, 8'hE2);
    ex(3'b001, 8'hE0); ex(3'b001, 8'hE1);
    req_en = 3'b001; vld_en = 3'b001;
    base = n_starts;
    wait_starts(base + 2, 100, "t5_two_bytes");
    vld_en = 3'b000;
    req_en = 3'b000;
    base = abort_cnt;
    fc = bus.Frame_cnt;
`ifdef ARB_TIMEOUT_EN
    repeat (TB_TIMEOUT + 20) @(negedge Clk);
    check("t5_abort_pulses", 32'(abort_cnt - base), 32'd1);
    check("t5_abort_delay", 32'(last_abort - prev_start), 32'(TB_TIMEOUT + 5));
    check("t5_grant_cleared", 32'(bus.Grant), 32'd0);
    check("t5_busy_cleared", 32'(bus.Busy), 32'd0);
    check("t5_frame_cnt_kept", 32'(bus.Frame_cnt), 32'(fc));
    flush_src();
`else
    repeat (60) @(negedge Clk);
    check("t5_no_abort", 32'(abort_cnt - base), 32'd0);
    check("t5_grant_held", 32'(bus.Grant), 32'b001);
    check("t5_still_busy", 32'(bus.Busy), 32'd1);
    check("t5_no_ready", 32'(bus.Ready), 32'd0);
    check("t5_frame_cnt_kept", 32'(bus.Frame_cnt), 32'(fc));
    ex(3'b001, 8'hE2);
    vld_en = 3'b001;
    wait_frames(fc + 16'd1, 100, "t5_frame_resumed");
`endif
    check("t5_exp_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame while waiting on UART busy
    busy_len = 50;
    sp(1, 1'b0, 8'hF0); sp(1, 1'b1, 8'hF1);
    ex(3'b010, 8'hF0);
    req_en = 3'b010; vld_en = 3'b010;
    base = n_starts;
    wait_starts(base + 1, 100, "t6_first_byte");
    repeat (5) @(negedge Clk);
    check("t6_in_frame", 32'(bus.Busy), 32'd1);
    @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    check("t6_exp_drained", 32'(exp_q.size()), 32'd0);
    flush_src();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    idle = 0;
    while (bus.Tx_busy && idle < 100) begin
      idle++;
      @(negedge Clk);
    end
    check("t6_uart_drained", 32'(bus.Tx_busy), 32'd0);
    sp(0, 1'b1, 8'h90); sp(1, 1'b1, 8'h91); sp(2, 1'b1, 8'h92);
    ex(3'b001, 8'h90); ex(3'b010, 8'h91); ex(3'b100, 8'h92);
    req_en = 3'b111; vld_en = 3'b111;
    wait_frames(16'd3, 1000, "t6_frame_cnt");
    check("t6_exp_drained_end", 32'(exp_q.size()), 32'd0);
`ifndef ARB_TIMEOUT_EN
    check("abort_never", 32'(abort_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
